// File: rtl/eeprom_pkg.sv
// Shared constants and state encoding for the EEPROM transaction sequencer.
package eeprom_pkg;

  localparam logic [6:0] DEV_ADDR_DEF    = 7'h50;
  localparam int         TWR_CYC_DEF     = 250_000;
  localparam int         GAP_CYC_DEF     = 8;
  localparam int         TIMEOUT_CYC_DEF = 4096;

  // One-hot encoding, matching the byte engine below us.
  typedef enum logic [9:0] {
    S_IDLE   = 10'b00_0000_0001,
    S_W_DEV  = 10'b00_0000_0010,
    S_W_ADDR = 10'b00_0000_0100,
    S_W_DATA = 10'b00_0000_1000,
    S_STOP1  = 10'b00_0001_0000,
    S_TWR    = 10'b00_0010_0000,
    S_R_DEV  = 10'b00_0100_0000,
    S_R_DATA = 10'b00_1000_0000,
    S_STOP2  = 10'b01_0000_0000,
    S_FIN    = 10'b10_0000_0000
  } state_e;

  // One width for every wait counter, large enough for the longest wait.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/eeprom_wait_cnt.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module eeprom_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// 24Cxx byte-write / random-read sequencer sitting above the IIC byte engine.
//
// state    | meaning
// IDLE     | waiting for req
// W_DEV    | frame 1, sending device address + W
// W_ADDR   | frame 1, sending word address
// W_DATA   | frame 1, sending write data
// STOP1    | iic_en low, bus-free gap after frame 1
// TWR      | iic_en low, EEPROM internal write time
// R_DEV    | frame 2, sending device address + R
// R_DATA   | frame 2, receiving data byte (SDA released)
// STOP2    | iic_en low, closing gap (also the abort path)
// FIN      | done pulse, busy released
module eeprom_ctrl
  import eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
  parameter int         TWR_CYC     = TWR_CYC_DEF,
  parameter int         GAP_CYC     = GAP_CYC_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       iic_en_o,
  output logic [7:0] iic_data_o,
  input  logic       iic_flag_i,
  input  logic [7:0] iic_readdata_i
);

  localparam int CW = cnt_width(TWR_CYC, GAP_CYC, TIMEOUT_CYC);

  state_e     state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       en_q, en_d;
  logic [7:0] data_q, data_d;
  logic       byte_st, entry, gap_zero, twr_zero, wd_zero;

  assign byte_st = state_q inside {S_W_DEV, S_W_ADDR, S_W_DATA, S_R_DEV, S_R_DATA};
  assign entry   = (state_d != state_q);

  // Waits are loaded with N-1 so the state lasts exactly N cycles.
  eeprom_wait_cnt #(.W(CW)) u_gap (
    .clk_i, .rst_ni,
    .load_i    (entry && (state_d inside {S_STOP1, S_STOP2})),
    .load_val_i(CW'(GAP_CYC - 1)),
    .dec_i     (state_q inside {S_STOP1, S_STOP2}),
    .zero_o    (gap_zero)
  );

  eeprom_wait_cnt #(.W(CW)) u_twr (
    .clk_i, .rst_ni,
    .load_i    (entry && (state_d == S_TWR)),
    .load_val_i(CW'(TWR_CYC - 1)),
    .dec_i     (state_q == S_TWR),
    .zero_o    (twr_zero)
  );

  eeprom_wait_cnt #(.W(CW)) u_wdog (
    .clk_i, .rst_ni,
    .load_i    (entry || iic_flag_i),
    .load_val_i(CW'(TIMEOUT_CYC - 1)),
    .dec_i     (byte_st),
    .zero_o    (wd_zero)
  );

  // State and output registers; iic_en drops immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  // Next state; engine outputs change only on state entry or on iic_flag.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    en_d    = en_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (req_i) begin
        rw_d    = rw_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        state_d = S_W_DEV;
        en_d    = 1'b1;
        data_d  = {DEV_ADDR, 1'b0};
      end
      S_W_DEV: if (iic_flag_i) begin
        state_d = S_W_ADDR;
        data_d  = addr_q;
      end
      S_W_ADDR: if (iic_flag_i) begin
        if (!rw_q) begin
          state_d = S_W_DATA;
          data_d  = wdata_q;
        end else begin
          state_d = S_STOP1;
          en_d    = 1'b0;
          data_d  = 8'hFF;
        end
      end
      S_W_DATA: if (iic_flag_i) begin
        state_d = S_STOP1;
        en_d    = 1'b0;
        data_d  = 8'hFF;
      end
      S_STOP1: if (gap_zero) begin
        if (rw_q) begin
          state_d = S_R_DEV;
          en_d    = 1'b1;
          data_d  = {DEV_ADDR, 1'b1};
        end else begin
          state_d = S_TWR;
        end
      end
      S_TWR: if (twr_zero) begin
        state_d = S_FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_R_DEV: if (iic_flag_i) begin
        state_d = S_R_DATA;
        data_d  = 8'hFF;
      end
      S_R_DATA: if (iic_flag_i) begin
        rdata_d = iic_readdata_i;
        state_d = S_STOP2;
        en_d    = 1'b0;
      end
      S_STOP2: if (gap_zero) begin
        state_d = S_FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // A missing byte-complete aborts through STOP2 so done still pulses once.
    if (byte_st && !iic_flag_i && wd_zero) begin
      state_d = S_STOP2;
      en_d    = 1'b0;
      err_d   = 1'b1;
      data_d  = 8'hFF;
    end
  end

  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign iic_en_o   = en_q;
  assign iic_data_o = data_q;

endmodule
